// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared definitions for the game-side register peer:
//                command op codes, command/point/status field positions,
//                board size defaults, controller states and the piece LFSR
//                step function.
//  Revision    : 1.0  initial release
// ============================================================================
package game_pkg;

    localparam int COLS_DEFAULT = 10;
    localparam int ROWS_DEFAULT = 20;

    // Command word op codes (data_to_game[27:24])
    localparam logic [3:0] OP_NOP         = 4'd0;
    localparam logic [3:0] OP_SET         = 4'd1;
    localparam logic [3:0] OP_CLR         = 4'd2;
    localparam logic [3:0] OP_QUERY       = 4'd3;
    localparam logic [3:0] OP_CLEAR_LINES = 4'd4;
    localparam logic [3:0] OP_CLEAR_BOARD = 4'd5;
    localparam logic [3:0] OP_NEXT_PIECE  = 4'd6;

    // Command word field positions
    localparam int CMD_TAG_LSB = 28;
    localparam int CMD_OP_LSB  = 24;

    // point_xy field positions
    localparam int PT_X_LSB = 8;
    localparam int PT_Y_LSB = 0;

    // Status word field positions
    localparam int ST_TAG_LSB   = 28;
    localparam int ST_BUSY_BIT  = 27;
    localparam int ST_QUERY_BIT = 26;
    localparam int ST_LL_LSB    = 21;
    localparam int ST_LT_LSB    = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_SCAN  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4,
        ST_PIECE = 3'd5
    } game_state_t;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting right.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/piece_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : piece_lfsr
//  Description : Piece generator LFSR. Advances one step per cycle while
//                step is high. value is the low three bits the register
//                holds after the pending step, so the controller can accept
//                or reject a candidate in the same cycle it shifts.
//  Ports       : clock, ctrl_reset (async, active-high)
//                step   in   advance the register this cycle
//                state  out  current 16-bit register contents
//                value  out  state[2:0] after the step
//  Revision    : 1.0  initial release
// ============================================================================
module piece_lfsr
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        step,
    output logic [15:0] state,
    output logic [2:0]  value
);

    logic [15:0] state_next;

    assign state_next = lfsr_next(state);
    assign value      = state_next[2:0];

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state <= SEED;
        end else if (step) begin
            state <= state_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/game_board_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_board_ctrl
//  Description : Game-side peer of the CPU's memory-mapped game registers.
//                Holds the Tetris occupancy board, executes tagged commands
//                (set/clear/query cell, line clear, board clear, next piece)
//                and publishes a status word plus the next shape id.
//  Ports       : clock, ctrl_reset (async, active-high)
//                data_to_game   in  32  command: [31:28] tag, [27:24] op
//                point_xy       in  32  [15:8] x column, [7:0] y row
//                data_from_game out 32  status word
//                shape_num      out 32  next piece id in [2:0]
//                disp_row_sel   in  5   display row select
//                disp_row_data  out COLS occupancy of selected row
//  Revision    : 1.0  initial release
// ============================================================================
module game_board_ctrl
    import game_pkg::*;
#(
    parameter int          COLS      = COLS_DEFAULT,
    parameter int          ROWS      = ROWS_DEFAULT,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic            clock,
    input  logic            ctrl_reset,
    input  logic [31:0]     data_to_game,
    input  logic [31:0]     point_xy,
    output logic [31:0]     data_from_game,
    output logic [31:0]     shape_num,
    input  logic [4:0]      disp_row_sel,
    output logic [COLS-1:0] disp_row_data
);

    localparam int              ROW_W    = $clog2(ROWS);
    localparam int              COL_W    = $clog2(COLS);
    localparam logic [7:0]      COLS_LIM = 8'(COLS);
    localparam logic [7:0]      ROWS_LIM = 8'(ROWS);
    localparam logic [4:0]      ROWS_SEL = 5'(ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    game_state_t fsm_state, fsm_state_next;

    logic [COLS-1:0]  board [ROWS];
    logic [3:0]       last_tag, cur_tag, op_l;
    logic [7:0]       x_l, y_l;
    logic             busy, query_bit;
    logic [4:0]       lines_last;
    logic [15:0]      lines_total;
    logic [2:0]       shape;
    logic [ROW_W-1:0] r_idx, k_idx;

    logic [3:0]       tag_in, op_in;
    logic             new_cmd, in_bounds, row_full, piece_ok, lfsr_step;
    logic [ROW_W-1:0] y_idx;
    logic [COL_W-1:0] x_idx;
    logic [15:0]      lfsr_state;
    logic [2:0]       lfsr_value;
    logic [31:0]      status_word;
    logic             unused_bits;

    assign tag_in    = data_to_game[CMD_TAG_LSB +: 4];
    assign op_in     = data_to_game[CMD_OP_LSB +: 4];
    assign new_cmd   = (tag_in != last_tag);
    assign in_bounds = (x_l < COLS_LIM) && (y_l < ROWS_LIM);
    assign y_idx     = y_l[ROW_W-1:0];
    assign x_idx     = x_l[COL_W-1:0];
    assign row_full  = &board[r_idx];
    assign piece_ok  = (lfsr_value != 3'd7);
    assign lfsr_step = (fsm_state == ST_PIECE);

    assign unused_bits = ^{data_to_game[23:0], point_xy[31:16], lfsr_state};

    piece_lfsr #(
        .SEED (LFSR_SEED)
    ) u_piece_lfsr (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .step       (lfsr_step),
        .state      (lfsr_state),
        .value      (lfsr_value)
    );

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            fsm_state <= ST_IDLE;
        end else begin
            fsm_state <= fsm_state_next;
        end
    end

    always_comb begin
        fsm_state_next = fsm_state;
        case (fsm_state)
            ST_IDLE: begin
                if (new_cmd) begin
                    case (op_in)
                        OP_CLEAR_LINES: fsm_state_next = ST_SCAN;
                        OP_NEXT_PIECE:  fsm_state_next = ST_PIECE;
                        default:        fsm_state_next = ST_EXEC;
                    endcase
                end
            end
            ST_EXEC:  fsm_state_next = ST_IDLE;
            ST_SCAN: begin
                if (row_full) begin
                    fsm_state_next = ST_SHIFT;
                end else if (r_idx == '0) begin
                    fsm_state_next = ST_DONE;
                end
            end
            // Returning to SCAN keeps r_idx so the row just shifted in is retested.
            ST_SHIFT: if (k_idx == '0) fsm_state_next = ST_SCAN;
            ST_DONE:  fsm_state_next = ST_IDLE;
            ST_PIECE: if (piece_ok) fsm_state_next = ST_IDLE;
            default:  fsm_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 0; i < ROWS; i++) board[i] <= '0;
            last_tag    <= '0;
            cur_tag     <= '0;
            op_l        <= '0;
            x_l         <= '0;
            y_l         <= '0;
            busy        <= 1'b0;
            query_bit   <= 1'b0;
            lines_last  <= '0;
            lines_total <= '0;
            shape       <= '0;
            r_idx       <= '0;
            k_idx       <= '0;
        end else begin
            case (fsm_state)
                ST_IDLE: begin
                    if (new_cmd) begin
                        cur_tag <= tag_in;
                        op_l    <= op_in;
                        x_l     <= point_xy[PT_X_LSB +: 8];
                        y_l     <= point_xy[PT_Y_LSB +: 8];
                        busy    <= 1'b1;
                        r_idx   <= LAST_ROW;
                        if (op_in == OP_CLEAR_LINES) lines_last <= '0;
                    end
                end
                ST_EXEC: begin
                    case (op_l)
                        OP_SET: if (in_bounds) board[y_idx][x_idx] <= 1'b1;
                        OP_CLR: if (in_bounds) board[y_idx][x_idx] <= 1'b0;
                        // Outside the board reads as occupied so collision checks see walls.
                        OP_QUERY: query_bit <= in_bounds ? board[y_idx][x_idx] : 1'b1;
                        OP_CLEAR_BOARD: begin
                            for (int i = 0; i < ROWS; i++) board[i] <= '0;
                            lines_total <= '0;
                        end
                        default: ;
                    endcase
                    last_tag <= cur_tag;
                    busy     <= 1'b0;
                end
                ST_SCAN: begin
                    if (row_full) begin
                        if (lines_last != 5'd31)       lines_last  <= lines_last + 5'd1;
                        if (lines_total != 16'hFFFF)   lines_total <= lines_total + 16'd1;
                        k_idx <= r_idx;
                    end else if (r_idx != '0) begin
                        r_idx <= r_idx - ROW_ONE;
                    end
                end
                ST_SHIFT: begin
                    if (k_idx == '0) begin
                        board[0] <= '0;
                    end else begin
                        board[k_idx] <= board[k_idx - ROW_ONE];
                        k_idx        <= k_idx - ROW_ONE;
                    end
                end
                ST_DONE: begin
                    last_tag <= cur_tag;
                    busy     <= 1'b0;
                end
                ST_PIECE: begin
                    if (piece_ok) begin
                        shape    <= lfsr_value;
                        last_tag <= cur_tag;
                        busy     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every field is a flop; this only places them in the word.
    always_comb begin
        status_word                      = '0;
        status_word[ST_TAG_LSB +: 4]     = last_tag;
        status_word[ST_BUSY_BIT]         = busy;
        status_word[ST_QUERY_BIT]        = query_bit;
        status_word[ST_LL_LSB +: 5]      = lines_last;
        status_word[ST_LT_LSB +: 16]     = lines_total;
    end

    assign data_from_game = status_word;
    assign shape_num      = {29'd0, shape};
    assign disp_row_data  = (disp_row_sel < ROWS_SEL) ? board[disp_row_sel[ROW_W-1:0]] : '0;

endmodule
`default_nettype wire
